// File: rtl/bb_loop_filter.sv
// Bang-bang PI loop filter: turns the 1-bit phase-detector decision stream into a
// saturating frequency control word, and tracks lock from the pattern of decisions.
module bb_loop_filter #(
    parameter int CTRL_WIDTH = 9,
    parameter int FRAC_BITS  = 4,
    parameter int KP_STEP    = 8,
    parameter int KI_STEP    = 2,
    parameter int CENTER     = 256,
    parameter int LOCK_COUNT = 16,
    parameter int UNLOCK_RUN = 8
) (
    input  logic                  fpga_clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  sample_i,
    input  logic                  pd_dir_i,
    output logic [CTRL_WIDTH-1:0] k_val_o,
    output logic                  k_valid_o,
    output logic                  locked_o,
    output logic                  sat_o
);

    localparam int INT_WIDTH = CTRL_WIDTH + FRAC_BITS;
    localparam int SUM_WIDTH = CTRL_WIDTH + 2;
    localparam int ALT_WIDTH = $clog2(LOCK_COUNT + 1);
    localparam int RUN_WIDTH = $clog2(UNLOCK_RUN + 1);

    localparam logic [0:0] ACQUIRE = 1'b0;
    localparam logic [0:0] TRACK   = 1'b1;

    localparam logic [INT_WIDTH-1:0] INTEG_MAX   = '1;
    localparam logic [INT_WIDTH-1:0] INTEG_RESET = INT_WIDTH'(CENTER << FRAC_BITS);
    localparam logic [INT_WIDTH-1:0] KI          = INT_WIDTH'(KI_STEP);
    localparam logic [SUM_WIDTH-1:0] KP          = SUM_WIDTH'(KP_STEP);
    localparam logic [ALT_WIDTH-1:0] ALT_MAX     = ALT_WIDTH'(LOCK_COUNT);
    localparam logic [RUN_WIDTH-1:0] RUN_MAX     = RUN_WIDTH'(UNLOCK_RUN);

    logic                  accept;
    logic [INT_WIDTH-1:0]  integ;
    logic [INT_WIDTH-1:0]  integ_nxt;
    logic [INT_WIDTH:0]    integ_up;
    logic                  integ_clip;
    logic                  integ_clip_q;
    logic                  dir_q;
    logic                  s1_valid;
    logic [SUM_WIDTH-1:0]  sum;
    logic [CTRL_WIDTH-1:0] k_nxt;
    logic                  out_clip;
    logic [0:0]            state;
    logic                  prev_valid;
    logic                  prev_dir;
    logic [ALT_WIDTH-1:0]  alt_cnt;
    logic [ALT_WIDTH-1:0]  alt_nxt;
    logic [RUN_WIDTH-1:0]  run_cnt;
    logic [RUN_WIDTH-1:0]  run_nxt;

    assign accept   = sample_i & enable_i & ~reset_i;
    assign integ_up = {1'b0, integ} + {1'b0, KI};
    assign locked_o = (state == TRACK);

    // Integral step with clamping at both rails; the clip flag rides along to stage 2.
    always_comb begin
        integ_nxt  = integ;
        integ_clip = 1'b0;
        if (pd_dir_i) begin
            if (integ_up[INT_WIDTH]) begin
                integ_nxt  = INTEG_MAX;
                integ_clip = 1'b1;
            end else begin
                integ_nxt = integ_up[INT_WIDTH-1:0];
            end
        end else if (integ < KI) begin
            integ_nxt  = '0;
            integ_clip = 1'b1;
        end else begin
            integ_nxt = integ - KI;
        end
    end

    // Two guard bits expose both underflow (sign) and overflow of the P+I sum.
    always_comb begin
        sum      = dir_q ? {2'b00, integ[INT_WIDTH-1:FRAC_BITS]} + KP
                         : {2'b00, integ[INT_WIDTH-1:FRAC_BITS]} - KP;
        k_nxt    = sum[CTRL_WIDTH-1:0];
        out_clip = 1'b0;
        if (sum[SUM_WIDTH-1]) begin
            k_nxt    = '0;
            out_clip = 1'b1;
        end else if (sum[CTRL_WIDTH]) begin
            k_nxt    = '1;
            out_clip = 1'b1;
        end
    end

    always_comb begin
        alt_nxt = alt_cnt;
        run_nxt = run_cnt;
        if (dir_q != prev_dir) begin
            alt_nxt = (alt_cnt == ALT_MAX) ? alt_cnt : alt_cnt + 1'b1;
            run_nxt = RUN_WIDTH'(1);
        end else begin
            run_nxt = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
            alt_nxt = '0;
        end
    end

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            integ        <= INTEG_RESET;
            integ_clip_q <= 1'b0;
            dir_q        <= 1'b0;
            s1_valid     <= 1'b0;
            k_val_o      <= CTRL_WIDTH'(CENTER);
            k_valid_o    <= 1'b0;
            sat_o        <= 1'b0;
            state        <= ACQUIRE;
            prev_valid   <= 1'b0;
            prev_dir     <= 1'b0;
            alt_cnt      <= '0;
            run_cnt      <= '0;
        end else begin
            s1_valid  <= accept;
            k_valid_o <= s1_valid;
            if (accept) begin
                integ        <= integ_nxt;
                integ_clip_q <= integ_clip;
                dir_q        <= pd_dir_i;
            end
            if (s1_valid) begin
                k_val_o <= k_nxt;
                sat_o   <= integ_clip_q | out_clip;
            end
            // Disabling drops lock history; an in-flight update still lands on k_val_o.
            if (!enable_i) begin
                state      <= ACQUIRE;
                prev_valid <= 1'b0;
                alt_cnt    <= '0;
                run_cnt    <= '0;
            end else if (s1_valid) begin
                prev_valid <= 1'b1;
                prev_dir   <= dir_q;
                if (prev_valid) begin
                    alt_cnt <= alt_nxt;
                    run_cnt <= run_nxt;
                    if (state == ACQUIRE && alt_nxt == ALT_MAX) begin
                        state <= TRACK;
                    end else if (state == TRACK && run_nxt == RUN_MAX) begin
                        state <= ACQUIRE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bb_loop_filter.sv
// Scoreboard bench for bb_loop_filter: stimulus pushes hand-computed expectations,
// per-instance monitors pop and compare on every k_valid_o pulse.
module tb_bb_loop_filter;

    typedef struct {
        logic [8:0] k;
        logic       sat;
        logic       lock;
        bit         chk;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic       sample = 1'b0;
    logic       pd_dir = 1'b0;
    logic       sample0 = 1'b0;
    logic       pd_dir0 = 1'b0;
    logic [8:0] k_val, k_val0;
    logic       k_valid, k_valid0, locked, locked0, sat, sat0;

    exp_t q[$];
    exp_t q0[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    bb_loop_filter dut (
        .fpga_clk_i(clk), .reset_i(reset), .enable_i(enable), .sample_i(sample),
        .pd_dir_i(pd_dir), .k_val_o(k_val), .k_valid_o(k_valid), .locked_o(locked), .sat_o(sat)
    );

    bb_loop_filter #(.CENTER(0)) dut0 (
        .fpga_clk_i(clk), .reset_i(reset), .enable_i(enable), .sample_i(sample0),
        .pd_dir_i(pd_dir0), .k_val_o(k_val0), .k_valid_o(k_valid0), .locked_o(locked0), .sat_o(sat0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (k_valid) begin
            if (q.size() == 0) begin
                check("k_valid_unexpected", k_valid, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("latency", cyc, e.due);
                if (e.chk) begin
                    check("k_val", k_val, e.k);
                    check("sat", sat, e.sat);
                    check("locked", locked, e.lock);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (k_valid0) begin
            if (q0.size() == 0) begin
                check("k_valid0_unexpected", k_valid0, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("latency0", cyc, e.due);
                if (e.chk) begin
                    check("k_val0", k_val0, e.k);
                    check("sat0", sat0, e.sat);
                    check("locked0", locked0, e.lock);
                end
            end
        end
    end

    function automatic exp_t mk(input logic [8:0] k, input logic s, input logic l, input bit c);
        exp_t e;
        e.k = k; e.sat = s; e.lock = l; e.chk = c; e.due = 0;
        return e;
    endfunction

    // One sample per call; consecutive calls give back-to-back samples.
    task automatic applyStimulus(input logic dir, input exp_t e, input bit push, input bit to_zero);
        @(negedge clk);
        e.due = cyc + 2;
        if (to_zero) begin
            sample0 = 1'b1; pd_dir0 = dir;
            if (push) q0.push_back(e);
        end else begin
            sample = 1'b1; pd_dir = dir;
            if (push) q.push_back(e);
        end
    endtask

    task automatic drain();
        @(negedge clk);
        sample = 1'b0; sample0 = 1'b0;
        for (int i = 0; i < 20 && (q.size() != 0 || q0.size() != 0); i++) @(negedge clk);
        check("drain_q", q.size(), 0);
        check("drain_q0", q0.size(), 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1; sample = 1'b0; sample0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [8:0] k, input logic s, input logic l);
        check({tag, "_k_val"}, k_val, k);
        check({tag, "_sat"}, sat, s);
        check({tag, "_locked"}, locked, l);
        check({tag, "_k_valid"}, k_valid, 0);
    endtask

    initial begin
        doReset();
        checkOutput("reset", 9'd256, 1'b0, 1'b0);

        applyStimulus(1'b1, mk(9'd264, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
        drain();

        // 8 ups from 4096: integ = 4096+2j, k crosses to 265 only at j=8; then a down step.
        doReset();
        for (int j = 1; j <= 8; j++)
            applyStimulus(1'b1, mk((j == 8) ? 9'd265 : 9'd264, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
        applyStimulus(1'b0, mk(9'd248, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
        drain();

        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sample = 1'b1; pd_dir = 1'b1;
        end
        @(negedge clk);
        sample = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("disabled", 9'd248, 1'b0, 1'b0);
        enable = 1'b1;
        applyStimulus(1'b1, mk(9'd265, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
        drain();

        // 17 alternating samples lock; run count restarts at the 17th, so the 7th up unlocks.
        doReset();
        for (int i = 1; i <= 17; i++)
            applyStimulus(i[0], mk(i[0] ? 9'd264 : 9'd248, 1'b0, (i == 17), 1'b1), 1'b1, 1'b0);
        for (int j = 1; j <= 8; j++)
            applyStimulus(1'b1, mk((j >= 7) ? 9'd265 : 9'd264, 1'b0, (j <= 6), 1'b1), 1'b1, 1'b0);
        drain();

        doReset();
        for (int i = 1; i <= 17; i++)
            applyStimulus(i[0], mk(i[0] ? 9'd264 : 9'd248, 1'b0, (i == 17), 1'b1), 1'b1, 1'b0);
        drain();
        check("locked_before_disable", locked, 1);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("locked_after_disable", locked, 0);
        @(negedge clk);
        enable = 1'b1;

        applyStimulus(1'b1, mk(9'd264, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
        drain();
        check("pre_midreset_k_val", k_val, 264);
        applyStimulus(1'b1, mk(9'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
        @(negedge clk);
        sample = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset", 9'd256, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("midreset_no_late_pulse_q", q.size(), 0);

        doReset();
        check("center0_reset_k_val", k_val0, 0);
        applyStimulus(1'b0, mk(9'd0, 1'b1, 1'b0, 1'b1), 1'b1, 1'b1);
        drain();

        // Integ reaches 8192 -> clamps at 8191 after 2048 ups; output clamps at 511.
        doReset();
        for (int i = 1; i <= 4100; i++)
            applyStimulus(1'b1, mk(9'd511, 1'b1, 1'b0, (i == 4100)), 1'b1, 1'b0);
        drain();
        check("sat_hold_k_val", k_val, 511);
        check("sat_hold_sat", sat, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/bb_loop_filter.md
# bb_loop_filter

Parametrised digital loop filter for the ADPLL. It converts the 1-bit bang-bang phase-detector decision stream into a multi-bit frequency control word for the phase accumulator or a multi-bit oscillator select. It implements a saturating proportional-integral (PI) filter and a lock detector. It sits between the phase detector and the controlled oscillator, clocked from the 160 MHz fabric clock. It replaces the direct PD-to-oscillator-select-bit connection.

## Interface
- CTRL_WIDTH, 9: control word width (matches phase-accumulator k value)
- FRAC_BITS, 4: fractional bits in integral accumulator; INT_WIDTH = CTRL_WIDTH+FRAC_BITS
- KP_STEP, 8: proportional step, in control-word LSBs
- KI_STEP, 2: integral step, in accumulator LSBs (1/2^FRAC_BITS control LSB)
- CENTER, 256: reset/start control word
- LOCK_COUNT, 16: consecutive alternations required to declare lock
- UNLOCK_RUN, 8: consecutive same-direction samples that drop lock
- fpga_clk_i  in  1  fabric clock
- reset_i  in  1  synchronous, active-high reset
- enable_i  in  1  filter enable
- sample_i  in  1  one-cycle strobe: pd_dir_i valid this cycle
- pd_dir_i  in  1  1 = generated clock lags (raise frequency), 0 = leads (lower)
- k_val_o  out  CTRL_WIDTH  frequency control word
- k_valid_o  out  1  one-cycle pulse when k_val_o updated
- locked_o  out  1  lock indicator
- sat_o  out  1  integrator or output clamped on last update

## Operation
- Accepted sample: sample_i & enable_i & !reset_i. Otherwise pd_dir_i is ignored.
- Stage 1, on an accepted sample: integ ± KI_STEP (+ if pd_dir_i=1), saturating to [0, 2^INT_WIDTH-1]. The direction is registered as dir_q.
- Stage 2, one cycle later: k_val_o = (integ >> FRAC_BITS) ± KP_STEP, using the sign of dir_q.
  - The sum is computed at CTRL_WIDTH+2 signed width and clamped to [0, 2^CTRL_WIDTH-1].
  - sat_o = 1 if either clamp was active for this update, else 0.
  - k_valid_o pulses.
- Between updates, k_val_o, sat_o and locked_o hold their values. The proportional term persists until the next sample.
- Lock FSM, evaluated at stage 2, with states ACQUIRE and TRACK:
  - prev_valid marks that a previous direction exists. The first accepted sample after reset or disable only sets prev_dir.
  - dir != prev_dir: alt_cnt++ (saturates at LOCK_COUNT), run_cnt = 1.
  - dir == prev_dir: run_cnt++ (saturates at UNLOCK_RUN), alt_cnt = 0.
  - ACQUIRE -> TRACK when alt_cnt reaches LOCK_COUNT.
  - TRACK -> ACQUIRE when run_cnt reaches UNLOCK_RUN.
  - locked_o = (state == TRACK).
- enable_i low:
  - integ and k_val_o hold.
  - FSM forced to ACQUIRE; alt_cnt, run_cnt and prev_valid cleared; locked_o = 0 on the next edge.
  - A stage-2 update already in flight still completes.
- Reset values:
  - integ = CENTER << FRAC_BITS; k_val_o = CENTER.
  - k_valid_o = 0; locked_o = 0; sat_o = 0.
  - FSM = ACQUIRE; all counters and prev_valid = 0; pipeline valid cleared.
- Reset mid-pipeline: the in-flight update is discarded.

## Timing
- Sample accepted in cycle n: integ is valid after edge n+1; k_val_o, sat_o and locked_o are valid after edge n+2; k_valid_o is high in cycle n+2.
- Back-to-back samples, one per cycle, are supported at full throughput. Each sample produces exactly one k_valid_o pulse, two cycles later.
- sample_i asserted together with reset_i: ignored.
- Enable falling in the same cycle as a sample: the sample is ignored.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset and single up sample:
  - After reset: k_val_o=256, locked_o=0, sat_o=0.
  - One sample with pd_dir_i=1 at cycle n: integ=4098, k_val_o=264, k_valid_o high in cycle n+2 only.
- Integration: 8 consecutive up samples at 1/cycle -> integ=4112, final k_val_o=265, 8 k_valid_o pulses. Then one down sample -> integ=4110, k_val_o=248.
- Saturation:
  - 4100 up samples -> integ=8191, k_val_o=511, sat_o=1.
  - After reset with CENTER=0, one down sample -> integ=0, k_val_o=0, sat_o=1.
- Lock acquire/release:
  - 17 alternating samples (1,0,1,...) -> locked_o rises two cycles after the 17th.
  - Then 8 consecutive up samples -> locked_o=0 two cycles after the 8th (run starts at the last alternation sample).
- Enable gating:
  - enable_i=0 with 10 strobes -> no k_valid_o, k_val_o unchanged.
  - Disable while locked -> locked_o=0 next cycle.
- Reset mid-operation: reset_i asserted in cycle n+1 after a sample -> no k_valid_o in n+2; outputs return to reset values.
